// File: rtl/preact_mac.sv
// Pre-activation MAC: bias + sum of VEC_LEN Q8.8 products, saturated to Q8.8 for the tanh stage.
// Optional macro PREACT_SAT_FLAG_EN adds the out_sat clamp indicator.
module preact_mac #(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] w,
  input  logic [15:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x
`ifdef PREACT_SAT_FLAG_EN
  ,
  output logic        out_sat
`endif
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-32768);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              out_x_q, out_x_d;
`ifdef PREACT_SAT_FLAG_EN
  logic                     sat_q, sat_d;
`endif

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic                     accept;

  assign prod     = $signed(a) * $signed(w);
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  // Bias is Q8.8; shifting left by 8 aligns it with the Q16.16 products.
  assign bias_ext = {{(ACC_W-24){bias[15]}}, bias, 8'h00};
  assign base     = (cnt_q == '0) ? bias_ext : acc_q;
  assign sum      = base + prod_ext;
  assign shifted  = sum >>> 8;
  assign accept   = in_valid && (state_q == ST_ACC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_x_d = out_x_q;
`ifdef PREACT_SAT_FLAG_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d = sum;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_OUT;
            if (shifted > Q_MAX) begin
              out_x_d = 16'h7FFF;
            end else if (shifted < Q_MIN) begin
              out_x_d = 16'h8000;
            end else begin
              out_x_d = shifted[15:0];
            end
`ifdef PREACT_SAT_FLAG_EN
            sat_d = (shifted > Q_MAX) || (shifted < Q_MIN);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_x_q <= 16'h0000;
`ifdef PREACT_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_x_q <= out_x_d;
`ifdef PREACT_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_x     = out_x_q;
`ifdef PREACT_SAT_FLAG_EN
  assign out_sat   = sat_q;
`endif

endmodule
